// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC generation, synchronous imem reads, output register plus
// one-entry skid, branch redirect. Optional halt-on-zero-word behaviour under IFETCH_HALT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_rd_adrs,
  input  logic [DATA_W-1:0] imem_rd_data,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic              rd_pending;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic              halted_q;

  logic              branch;
  logic              word_in;
  logic              consume;
  logic              slot_free;
  logic              out_load;
  logic              skid_load;
  logic [DATA_W-1:0] out_instr_n;
  logic [ADDR_W-1:0] out_pc_n;

  assign branch    = br_taken && cpu_en;
  // A word returning in the branch cycle belongs to the abandoned path.
  assign word_in   = rd_pending && !branch && !halted_q;
  assign consume   = if_valid && !id_stall && cpu_en;
  assign slot_free = !if_valid || consume;

  assign imem_rd_en   = resetn && (branch ||
                        (cpu_en && !halted_q && !skid_valid &&
                         !(if_valid && id_stall && rd_pending)));
  assign imem_rd_adrs = branch ? br_target : fetch_pc;
  assign halted       = halted_q;

  always_comb begin
    out_load    = 1'b0;
    skid_load   = 1'b0;
    out_instr_n = imem_rd_data;
    out_pc_n    = rd_pc;
    if (!branch) begin
      if (slot_free) begin
        if (skid_valid) begin
          out_load    = 1'b1;
          out_instr_n = skid_instr;
          out_pc_n    = skid_pc;
          skid_load   = word_in;
        end else if (word_in) begin
          out_load = 1'b1;
        end
      end else if (word_in) begin
        skid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc   <= ADDR_W'(RESET_PC);
      rd_pending <= 1'b0;
      rd_pc      <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      rd_pending <= imem_rd_en;
      if (imem_rd_en) begin
        rd_pc    <= imem_rd_adrs;
        fetch_pc <= imem_rd_adrs + ADDR_W'(1);
      end
      if (branch) begin
        if_valid   <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (out_load) begin
          if_valid <= 1'b1;
          if_instr <= out_instr_n;
          if_pc    <= out_pc_n;
        end else if (consume) begin
          if_valid <= 1'b0;
        end
        if (skid_load) begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rd_data;
          skid_pc    <= rd_pc;
        end else if (out_load && skid_valid) begin
          skid_valid <= 1'b0;
        end
      end
    end
  end

`ifdef IFETCH_HALT_EN
  // halted rises together with if_valid of the all-zero word.
  always_ff @(posedge clk) begin
    if (!resetn)
      halted_q <= 1'b0;
    else if (branch)
      halted_q <= 1'b0;
    else if (out_load && (out_instr_n == '0))
      halted_q <= 1'b1;
  end
`else
  assign halted_q = 1'b0;
`endif

endmodule
